// File: rtl/id_stage.sv
// Instruction decode stage for an RV32I pipeline. It decodes the fetched
// word, reads operands from the register file in the same cycle, detects
// hazards against the EX and MEM stages, and holds the result in one EX
// pipeline register.
module id_stage (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        if_valid_in,
    input  logic [31:0] if_pc_in,
    input  logic [31:0] if_inst_in,
    output logic        id_ready_out,
    output logic        read_flag_1,
    output logic        read_flag_2,
    output logic [4:0]  reg_read_1,
    output logic [4:0]  reg_read_2,
    input  logic [31:0] output_data_1,
    input  logic [31:0] output_data_2,
    input  logic        mem_rd_we_in,
    input  logic [4:0]  mem_rd_in,
    output logic        ex_valid_out,
    input  logic        ex_ready_in,
    output logic [31:0] ex_pc_out,
    output logic [31:0] ex_op1_out,
    output logic [31:0] ex_op2_out,
    output logic [31:0] ex_imm_out,
    output logic [4:0]  ex_rd_out,
    output logic        ex_rd_we_out,
    output logic [3:0]  ex_alu_op_out,
    output logic [2:0]  ex_kind_out,
    output logic [2:0]  ex_funct3_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] K_ALU    = 3'd0;
    localparam logic [2:0] K_LOAD   = 3'd1;
    localparam logic [2:0] K_STORE  = 3'd2;
    localparam logic [2:0] K_BRANCH = 3'd3;
    localparam logic [2:0] K_JAL    = 3'd4;
    localparam logic [2:0] K_JALR   = 3'd5;
    localparam logic [2:0] K_LUI    = 3'd6;
    localparam logic [2:0] K_AUIPC  = 3'd7;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_SLL  = 4'd2;
    localparam logic [3:0] A_SLT  = 4'd3;
    localparam logic [3:0] A_SLTU = 4'd4;
    localparam logic [3:0] A_XOR  = 4'd5;
    localparam logic [3:0] A_SRL  = 4'd6;
    localparam logic [3:0] A_SRA  = 4'd7;
    localparam logic [3:0] A_OR   = 4'd8;
    localparam logic [3:0] A_AND  = 4'd9;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    logic [2:0]  w_kind;
    logic [3:0]  w_alu_op;
    logic [31:0] w_imm;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_writes_rd;
    logic        w_op2_is_reg;
    logic        w_is_arith;
    logic        w_sub_ok;

    logic        w_haz_1, w_haz_2, w_hazard;
    logic        w_advance;
    logic        w_accept;
    logic [31:0] w_op1, w_op2;

    logic        r_ex_valid;
    logic [31:0] r_ex_pc, r_ex_op1, r_ex_op2, r_ex_imm;
    logic [4:0]  r_ex_rd;
    logic        r_ex_rd_we;
    logic [3:0]  r_ex_alu_op;
    logic [2:0]  r_ex_kind;
    logic [2:0]  r_ex_funct3;

    assign w_opcode = if_inst_in[6:0];
    assign w_rd     = if_inst_in[11:7];
    assign w_funct3 = if_inst_in[14:12];
    assign w_rs1    = if_inst_in[19:15];
    assign w_rs2    = if_inst_in[24:20];

    assign w_imm_i = {{20{if_inst_in[31]}}, if_inst_in[31:20]};
    assign w_imm_s = {{20{if_inst_in[31]}}, if_inst_in[31:25], if_inst_in[11:7]};
    assign w_imm_b = {{19{if_inst_in[31]}}, if_inst_in[31], if_inst_in[7],
                      if_inst_in[30:25], if_inst_in[11:8], 1'b0};
    assign w_imm_u = {if_inst_in[31:12], 12'b0};
    assign w_imm_j = {{11{if_inst_in[31]}}, if_inst_in[31], if_inst_in[19:12],
                      if_inst_in[20], if_inst_in[30:21], 1'b0};

    // Opcode decode: class, operand usage, immediate format; unknown opcodes fall through as a NOP
    always_comb begin
        w_kind       = K_ALU;
        w_imm        = 32'd0;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        w_writes_rd  = 1'b0;
        w_op2_is_reg = 1'b0;
        w_is_arith   = 1'b0;
        w_sub_ok     = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_writes_rd = 1'b1;
                w_op2_is_reg = 1'b1; w_is_arith = 1'b1; w_sub_ok = 1'b1;
            end
            OPC_OPIMM: begin
                w_use_rs1 = 1'b1; w_writes_rd = 1'b1; w_is_arith = 1'b1;
                w_imm = w_imm_i;
            end
            OPC_LOAD: begin
                w_kind = K_LOAD; w_use_rs1 = 1'b1; w_writes_rd = 1'b1;
                w_imm = w_imm_i;
            end
            OPC_STORE: begin
                w_kind = K_STORE; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_op2_is_reg = 1'b1; w_imm = w_imm_s;
            end
            OPC_BRANCH: begin
                w_kind = K_BRANCH; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_op2_is_reg = 1'b1; w_imm = w_imm_b;
            end
            OPC_JAL: begin
                w_kind = K_JAL; w_writes_rd = 1'b1; w_imm = w_imm_j;
            end
            OPC_JALR: begin
                w_kind = K_JALR; w_use_rs1 = 1'b1; w_writes_rd = 1'b1;
                w_imm = w_imm_i;
            end
            OPC_LUI: begin
                w_kind = K_LUI; w_writes_rd = 1'b1; w_imm = w_imm_u;
            end
            OPC_AUIPC: begin
                w_kind = K_AUIPC; w_writes_rd = 1'b1; w_imm = w_imm_u;
            end
            default: ;
        endcase
    end

    // ALU function select; inst[30] picks SUB only for register-register ops, SRA for both forms
    always_comb begin
        w_alu_op = A_ADD;
        if (w_is_arith) begin
            case (w_funct3)
                3'd0:    w_alu_op = (w_sub_ok && if_inst_in[30]) ? A_SUB : A_ADD;
                3'd1:    w_alu_op = A_SLL;
                3'd2:    w_alu_op = A_SLT;
                3'd3:    w_alu_op = A_SLTU;
                3'd4:    w_alu_op = A_XOR;
                3'd5:    w_alu_op = if_inst_in[30] ? A_SRA : A_SRL;
                3'd6:    w_alu_op = A_OR;
                default: w_alu_op = A_AND;
            endcase
        end
    end

    assign read_flag_1 = if_valid_in & w_use_rs1;
    assign read_flag_2 = if_valid_in & w_use_rs2;
    assign reg_read_1  = w_rs1;
    assign reg_read_2  = w_rs2;

    assign w_op1 = (w_rs1 == 5'd0) ? 32'd0 : output_data_1;
    assign w_op2 = w_op2_is_reg ? output_data_2 : w_imm;

    // Load-use style interlock: a source still being produced in EX or MEM stalls decode
    assign w_haz_1 = read_flag_1 && (w_rs1 != 5'd0) &&
                     ((r_ex_valid && r_ex_rd_we && (w_rs1 == r_ex_rd)) ||
                      (mem_rd_we_in && (w_rs1 == mem_rd_in)));
    assign w_haz_2 = read_flag_2 && (w_rs2 != 5'd0) &&
                     ((r_ex_valid && r_ex_rd_we && (w_rs2 == r_ex_rd)) ||
                      (mem_rd_we_in && (w_rs2 == mem_rd_in)));
    assign w_hazard = w_haz_1 | w_haz_2;

    assign w_advance    = rdy_in & (~r_ex_valid | ex_ready_in);
    // rst_in is folded in so nothing is offered as accepted while reset is held
    assign id_ready_out = rst_in & w_advance & ~w_hazard & ~flush_in;
    assign w_accept     = if_valid_in & id_ready_out;

    // EX pipeline register: load on accept, bubble on advance without accept, hold on stall
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_ex_valid  <= 1'b0;
            r_ex_pc     <= 32'd0;
            r_ex_op1    <= 32'd0;
            r_ex_op2    <= 32'd0;
            r_ex_imm    <= 32'd0;
            r_ex_rd     <= 5'd0;
            r_ex_rd_we  <= 1'b0;
            r_ex_alu_op <= 4'd0;
            r_ex_kind   <= 3'd0;
            r_ex_funct3 <= 3'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_ex_valid <= 1'b0;
                r_ex_rd_we <= 1'b0;
            end else if (w_advance) begin
                if (w_accept) begin
                    r_ex_valid  <= 1'b1;
                    r_ex_pc     <= if_pc_in;
                    r_ex_op1    <= w_op1;
                    r_ex_op2    <= w_op2;
                    r_ex_imm    <= w_imm;
                    r_ex_rd     <= w_rd;
                    r_ex_rd_we  <= w_writes_rd & (w_rd != 5'd0);
                    r_ex_alu_op <= w_alu_op;
                    r_ex_kind   <= w_kind;
                    r_ex_funct3 <= w_funct3;
                end else begin
                    r_ex_valid <= 1'b0;
                    r_ex_rd_we <= 1'b0;
                end
            end
        end
    end

    assign ex_valid_out  = r_ex_valid;
    assign ex_pc_out     = r_ex_pc;
    assign ex_op1_out    = r_ex_op1;
    assign ex_op2_out    = r_ex_op2;
    assign ex_imm_out    = r_ex_imm;
    assign ex_rd_out     = r_ex_rd;
    assign ex_rd_we_out  = r_ex_rd_we;
    assign ex_alu_op_out = r_ex_alu_op;
    assign ex_kind_out   = r_ex_kind;
    assign ex_funct3_out = r_ex_funct3;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode vector table plus hand-written
// sequences for hazards, stalls, flush, freeze and asynchronous reset.
module tb_id_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_valid_in;
    logic [31:0] if_pc_in;
    logic [31:0] if_inst_in;
    logic        id_ready_out;
    logic        read_flag_1, read_flag_2;
    logic [4:0]  reg_read_1, reg_read_2;
    logic [31:0] output_data_1, output_data_2;
    logic        mem_rd_we_in;
    logic [4:0]  mem_rd_in;
    logic        ex_valid_out;
    logic        ex_ready_in;
    logic [31:0] ex_pc_out, ex_op1_out, ex_op2_out, ex_imm_out;
    logic [4:0]  ex_rd_out;
    logic        ex_rd_we_out;
    logic [3:0]  ex_alu_op_out;
    logic [2:0]  ex_kind_out;
    logic [2:0]  ex_funct3_out;

    int checks = 0;
    int errors = 0;

    id_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_valid_in(if_valid_in), .if_pc_in(if_pc_in), .if_inst_in(if_inst_in),
        .id_ready_out(id_ready_out), .read_flag_1(read_flag_1), .read_flag_2(read_flag_2),
        .reg_read_1(reg_read_1), .reg_read_2(reg_read_2),
        .output_data_1(output_data_1), .output_data_2(output_data_2),
        .mem_rd_we_in(mem_rd_we_in), .mem_rd_in(mem_rd_in),
        .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in),
        .ex_pc_out(ex_pc_out), .ex_op1_out(ex_op1_out), .ex_op2_out(ex_op2_out),
        .ex_imm_out(ex_imm_out), .ex_rd_out(ex_rd_out), .ex_rd_we_out(ex_rd_we_out),
        .ex_alu_op_out(ex_alu_op_out), .ex_kind_out(ex_kind_out),
        .ex_funct3_out(ex_funct3_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] inst, d1, d2, op1, op2, imm;
        logic [2:0]  kind, f3;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        we, rf1, rf2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] inst, logic [31:0] d1, logic [31:0] d2,
                                logic [2:0] kind, logic [3:0] alu, logic [31:0] op1,
                                logic [31:0] op2, logic [31:0] imm, logic [4:0] rd,
                                logic we, logic [2:0] f3, logic rf1, logic rf2);
        vec_t v;
        v.inst = inst; v.d1 = d1; v.d2 = d2; v.kind = kind; v.alu = alu;
        v.op1 = op1; v.op2 = op2; v.imm = imm; v.rd = rd; v.we = we;
        v.f3 = f3; v.rf1 = rf1; v.rf2 = rf2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2);
        if_valid_in = 1'b1; if_inst_in = inst; if_pc_in = pc;
        output_data_1 = d1; output_data_2 = d2;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0;
        if_pc_in = 32'd0; if_inst_in = 32'd0; output_data_1 = 32'd0;
        output_data_2 = 32'd0; mem_rd_we_in = 1'b0; mem_rd_in = 5'd0;
        ex_ready_in = 1'b1;

        //            inst          d1            d2          kind alu op1          op2           imm           rd we f3 rf1 rf2
        vecs.push_back(mk(32'h00500093, 32'h0000AAAA, 32'h0, 3'd0, 4'd0, 32'h0,     32'h5,        32'h5,        5'd1,  1, 3'd0, 1, 0)); // addi x1,x0,5
        vecs.push_back(mk(32'h002081B3, 32'd10,       32'd20, 3'd0, 4'd0, 32'd10,   32'd20,       32'h0,        5'd3,  1, 3'd0, 1, 1)); // add x3,x1,x2
        vecs.push_back(mk(32'h407302B3, 32'd100,      32'd30, 3'd0, 4'd1, 32'd100,  32'd30,       32'h0,        5'd5,  1, 3'd0, 1, 1)); // sub x5,x6,x7
        vecs.push_back(mk(32'hFE208CE3, 32'd7,        32'd7,  3'd3, 4'd0, 32'd7,    32'd7,        32'hFFFFFFF8, 5'd25, 0, 3'd0, 1, 1)); // beq x1,x2,-8
        vecs.push_back(mk(32'h40315213, 32'h80,       32'h0,  3'd0, 4'd7, 32'h80,   32'h403,      32'h403,      5'd4,  1, 3'd5, 1, 0)); // srai x4,x2,3
        vecs.push_back(mk(32'h40030313, 32'd1,        32'h0,  3'd0, 4'd0, 32'd1,    32'h400,      32'h400,      5'd6,  1, 3'd0, 1, 0)); // addi x6,x6,1024
        vecs.push_back(mk(32'hFFC12383, 32'h1000,     32'h0,  3'd1, 4'd0, 32'h1000, 32'hFFFFFFFC, 32'hFFFFFFFC, 5'd7,  1, 3'd2, 1, 0)); // lw x7,-4(x2)
        vecs.push_back(mk(32'h0051A423, 32'h2000,     32'hDEAD, 3'd2, 4'd0, 32'h2000, 32'hDEAD,   32'h8,        5'd8,  0, 3'd2, 1, 1)); // sw x5,8(x3)
        vecs.push_back(mk(32'h010000EF, 32'h0,        32'h0,  3'd4, 4'd0, 32'h0,    32'h10,       32'h10,       5'd1,  1, 3'd0, 0, 0)); // jal x1,16
        vecs.push_back(mk(32'hFFDFF06F, 32'h0,        32'h0,  3'd4, 4'd0, 32'h0,    32'hFFFFFFFC, 32'hFFFFFFFC, 5'd0,  0, 3'd7, 0, 0)); // jal x0,-4
        vecs.push_back(mk(32'h00C280E7, 32'h300,      32'h0,  3'd5, 4'd0, 32'h300,  32'hC,        32'hC,        5'd1,  1, 3'd0, 1, 0)); // jalr x1,12(x5)
        vecs.push_back(mk(32'h12345537, 32'h0,        32'h0,  3'd6, 4'd0, 32'h0,    32'h12345000, 32'h12345000, 5'd10, 1, 3'd5, 0, 0)); // lui x10
        vecs.push_back(mk(32'hFFFFF597, 32'h0,        32'h0,  3'd7, 4'd0, 32'h0,    32'hFFFFF000, 32'hFFFFF000, 5'd11, 1, 3'd7, 0, 0)); // auipc x11
        vecs.push_back(mk(32'hFFFFFFFF, 32'h0,        32'h0,  3'd0, 4'd0, 32'h0,    32'h0,        32'h0,        5'd31, 0, 3'd7, 0, 0)); // unknown -> NOP
        vecs.push_back(mk(32'h00208033, 32'd3,        32'd4,  3'd0, 4'd0, 32'd3,    32'd4,        32'h0,        5'd0,  0, 3'd0, 1, 1)); // add x0,x1,x2
        vecs.push_back(mk(32'h00A4E433, 32'd1,        32'd2,  3'd0, 4'd8, 32'd1,    32'd2,        32'h0,        5'd8,  1, 3'd6, 1, 1)); // or x8,x9,x10

        // Reset state, including id_ready held low while reset is asserted
        #3;
        chk("rst_valid", 32'(ex_valid_out), 32'd0);
        chk("rst_pc", ex_pc_out, 32'd0);
        chk("rst_ready", 32'(id_ready_out), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Decode table: each vector is accepted into an empty EX, then checked one cycle later
        foreach (vecs[i]) begin
            @(posedge clk_in); #1;
            offer(vecs[i].inst, 32'h100 + 32'(i) * 4, vecs[i].d1, vecs[i].d2);
            @(negedge clk_in);
            chk($sformatf("v%0d_ready", i), 32'(id_ready_out), 32'd1);
            chk($sformatf("v%0d_rf1", i), 32'(read_flag_1), 32'(vecs[i].rf1));
            chk($sformatf("v%0d_rf2", i), 32'(read_flag_2), 32'(vecs[i].rf2));
            chk($sformatf("v%0d_rr1", i), 32'(reg_read_1), 32'(vecs[i].inst[19:15]));
            chk($sformatf("v%0d_rr2", i), 32'(reg_read_2), 32'(vecs[i].inst[24:20]));
            @(posedge clk_in); #1;
            if_valid_in = 1'b0;
            @(negedge clk_in);
            chk($sformatf("v%0d_valid", i), 32'(ex_valid_out), 32'd1);
            chk($sformatf("v%0d_pc", i), ex_pc_out, 32'h100 + 32'(i) * 4);
            chk($sformatf("v%0d_kind", i), 32'(ex_kind_out), 32'(vecs[i].kind));
            chk($sformatf("v%0d_alu", i), 32'(ex_alu_op_out), 32'(vecs[i].alu));
            chk($sformatf("v%0d_op1", i), ex_op1_out, vecs[i].op1);
            chk($sformatf("v%0d_op2", i), ex_op2_out, vecs[i].op2);
            chk($sformatf("v%0d_imm", i), ex_imm_out, vecs[i].imm);
            chk($sformatf("v%0d_rd", i), 32'(ex_rd_out), 32'(vecs[i].rd));
            chk($sformatf("v%0d_we", i), 32'(ex_rd_we_out), 32'(vecs[i].we));
            chk($sformatf("v%0d_f3", i), 32'(ex_funct3_out), 32'(vecs[i].f3));
            $display("vec %0d inst=%h kind=%0d alu=%0d op1=%h op2=%h", i, vecs[i].inst,
                     ex_kind_out, ex_alu_op_out, ex_op1_out, ex_op2_out);
        end
        @(posedge clk_in); #1;   // drain to an empty EX

        // RAW hazard: add x3,x1,x2 right behind addi x1 waits through EX and MEM
        offer(32'h00500093, 32'h200, 32'h0, 32'h0);
        @(negedge clk_in);
        chk("haz_first_ready", 32'(id_ready_out), 32'd1);
        @(posedge clk_in); #1;
        offer(32'h002081B3, 32'h204, 32'd5, 32'd6);
        @(negedge clk_in);
        chk("haz_ex_ready", 32'(id_ready_out), 32'd0);
        chk("haz_ex_valid", 32'(ex_valid_out), 32'd1);
        @(posedge clk_in); #1;
        mem_rd_we_in = 1'b1; mem_rd_in = 5'd1;
        @(negedge clk_in);
        chk("haz_bubble", 32'(ex_valid_out), 32'd0);
        chk("haz_mem_ready", 32'(id_ready_out), 32'd0);
        @(posedge clk_in); #1;
        mem_rd_we_in = 1'b0;
        @(negedge clk_in);
        chk("haz_clear_ready", 32'(id_ready_out), 32'd1);
        @(posedge clk_in); #1;
        if_valid_in = 1'b0;
        @(negedge clk_in);
        chk("haz_acc_valid", 32'(ex_valid_out), 32'd1);
        chk("haz_acc_rd", 32'(ex_rd_out), 32'd3);
        chk("haz_acc_op1", ex_op1_out, 32'd5);
        chk("haz_acc_op2", ex_op2_out, 32'd6);
        $display("hazard sequence done pc=%h", ex_pc_out);

        // Back-pressure: EX holds add x3 for 3 cycles while addi x9 is offered
        ex_ready_in = 1'b0;
        offer(32'h00700493, 32'h208, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            chk($sformatf("stall%0d_valid", k), 32'(ex_valid_out), 32'd1);
            chk($sformatf("stall%0d_pc", k), ex_pc_out, 32'h204);
            chk($sformatf("stall%0d_rd", k), 32'(ex_rd_out), 32'd3);
            chk($sformatf("stall%0d_op1", k), ex_op1_out, 32'd5);
            chk($sformatf("stall%0d_ready", k), 32'(id_ready_out), 32'd0);
        end
        ex_ready_in = 1'b1;
        #1;
        chk("stall_release_ready", 32'(id_ready_out), 32'd1);
        @(posedge clk_in); #1;
        if_valid_in = 1'b0;
        @(negedge clk_in);
        chk("stall_next_rd", 32'(ex_rd_out), 32'd9);
        chk("stall_next_op2", ex_op2_out, 32'd7);
        $display("stall sequence done pc=%h", ex_pc_out);

        // Flush while EX is stalled: EX empties and the offer is dropped
        ex_ready_in = 1'b0; flush_in = 1'b1;
        offer(32'h00500093, 32'h300, 32'h0, 32'h0);
        #1;
        chk("flush_ready", 32'(id_ready_out), 32'd0);
        @(posedge clk_in); #1;
        flush_in = 1'b0; if_valid_in = 1'b0; ex_ready_in = 1'b1;
        @(negedge clk_in);
        chk("flush_valid", 32'(ex_valid_out), 32'd0);
        $display("flush sequence done valid=%0d", ex_valid_out);

        // Global freeze: with rdy_in low nothing moves, not even a bubble
        offer(32'h00500093, 32'h400, 32'h0, 32'h0);
        @(posedge clk_in); #1;
        if_valid_in = 1'b0; rdy_in = 1'b0;
        @(negedge clk_in);
        chk("frz_ready", 32'(id_ready_out), 32'd0);
        offer(32'h00700493, 32'h500, 32'h0, 32'h0);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("frz_valid", 32'(ex_valid_out), 32'd1);
        chk("frz_pc", ex_pc_out, 32'h400);
        rdy_in = 1'b1; if_valid_in = 1'b0;
        $display("freeze sequence done pc=%h", ex_pc_out);

        // Asynchronous reset between edges in the middle of a stall
        ex_ready_in = 1'b0;
        @(posedge clk_in); #2;
        rst_in = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid_out), 32'd0);
        chk("arst_pc", ex_pc_out, 32'd0);
        chk("arst_op1", ex_op1_out, 32'd0);
        chk("arst_op2", ex_op2_out, 32'd0);
        chk("arst_imm", ex_imm_out, 32'd0);
        chk("arst_rd", 32'(ex_rd_out), 32'd0);
        chk("arst_we", 32'(ex_rd_we_out), 32'd0);
        chk("arst_alu", 32'(ex_alu_op_out), 32'd0);
        chk("arst_kind", 32'(ex_kind_out), 32'd0);
        chk("arst_f3", 32'(ex_funct3_out), 32'd0);
        offer(32'h00500093, 32'h600, 32'h0, 32'h0);
        ex_ready_in = 1'b1;
        #1;
        chk("arst_ready", 32'(id_ready_out), 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("arst_hold_valid", 32'(ex_valid_out), 32'd0);
        rst_in = 1'b1;
        #1;
        chk("post_rst_ready", 32'(id_ready_out), 32'd1);
        @(posedge clk_in); #1;
        if_valid_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_valid", 32'(ex_valid_out), 32'd1);
        chk("post_rst_pc", ex_pc_out, 32'h600);
        chk("post_rst_op2", ex_op2_out, 32'd5);
        chk("post_rst_rd", 32'(ex_rd_out), 32'd1);
        chk("post_rst_we", 32'(ex_rd_we_out), 32'd1);
        $display("reset sequence done pc=%h", ex_pc_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
